// File: rtl/alu_pkg.sv
// Shared ALU-datapath constants: default memory geometry, clear value, and
// write-memory sequencer state encoding.
// No ports; imported by ram_wr and ram_wr_clear_seq.
package alu_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 4;
  localparam logic [31:0] INIT_VAL_DEF = 32'h0000_0000;

  // CLEAR walks the array after reset; READY accepts traffic until next reset.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_wr_if.sv
// Write/read bus of the ALU writable data memory.
// master: drives wr_valid_i/wr_dir_i/wr_dat_i(/wr_be_i), rd_en_i/rd_dir_i;
// slave: drives wr_ready_o, rd_dat_o, rd_valid_o, init_done_o.
// RAM_BYTE_MASK_EN adds the per-byte write enable wr_be_i.
interface ram_wr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);

  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_dir_i;
  logic [DATA_W-1:0] wr_dat_i;
`ifdef RAM_BYTE_MASK_EN
  logic [DATA_W/8-1:0] wr_be_i;
`endif
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_dir_i;
  logic [DATA_W-1:0] rd_dat_o;
  logic              rd_valid_o;
  logic              init_done_o;

  modport master (
`ifdef RAM_BYTE_MASK_EN
    output wr_be_i,
`endif
    output wr_valid_i, wr_dir_i, wr_dat_i, rd_en_i, rd_dir_i,
    input  wr_ready_o, rd_dat_o, rd_valid_o, init_done_o
  );

  modport slave (
`ifdef RAM_BYTE_MASK_EN
    input  wr_be_i,
`endif
    input  wr_valid_i, wr_dir_i, wr_dat_i, rd_en_i, rd_dir_i,
    output wr_ready_o, rd_dat_o, rd_valid_o, init_done_o
  );

endinterface

// File: rtl/ram_wr_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then parks in READY.
// Ports: clk_i, rst_i (async active-high); clr_we/clr_addr drive the array
// clear write; init_done is the registered READY state.
module ram_wr_clear_seq
  import alu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        // Last entry is being written this cycle.
        if (ptr_q == {ADDR_W{1'b1}}) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr  = ptr_q;
  assign init_done = (state_q == READY);

endmodule

// File: rtl/ram_wr.sv
// 2**ADDR_W x DATA_W writable data memory for the ALU operand path: cleared to
// INIT_VAL after reset, then single-word valid/ready writes and 1-cycle reads.
// Ports: clk_i, rst_i (async active-high), bus (ram_wr_if.slave).
// Optional macro RAM_BYTE_MASK_EN: per-byte write enables on bus.wr_be_i.
module ram_wr
  import alu_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  ram_wr_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wr_commit;
  logic              rd_fire;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_dat_q;
  logic              rd_valid_q;

  ram_wr_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (ready)
  );

  // Ready is purely the registered FSM state, never a function of wr_valid_i.
  assign bus.wr_ready_o  = ready;
  assign bus.init_done_o = ready;

  assign wr_commit = bus.wr_valid_i & ready;
  assign rd_fire   = bus.rd_en_i & ready;

  // Array has no reset; the clear sequence overwrites it. The read below uses
  // the pre-edge contents, which gives read-first on same-address collisions.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL[DATA_W-1:0];
    end else if (wr_commit) begin
`ifdef RAM_BYTE_MASK_EN
      for (int b = 0; b < DATA_W/8; b++) begin
        if (bus.wr_be_i[b]) mem[bus.wr_dir_i][b*8 +: 8] <= bus.wr_dat_i[b*8 +: 8];
      end
`else
      mem[bus.wr_dir_i] <= bus.wr_dat_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_dat_q <= mem[bus.rd_dir_i];
    end
  end

  assign bus.rd_dat_o   = rd_dat_q;
  assign bus.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_ram_wr.sv
// Self-checking bench for ram_wr: reference memory model plus a queue of
// expected read data, compared when rd_valid_o is due.
// Build with RAM_BYTE_MASK_EN defined to also exercise the byte-mask path.
module tb_ram_wr;

  localparam int          DW   = 32;
  localparam int          AW   = 4;
  localparam int          NENT = 16;
  localparam logic [31:0] INIT = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_wr_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

  ram_wr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m [NENT];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          clr_cnt;
  logic        ready_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] cur_be();
`ifdef RAM_BYTE_MASK_EN
    return ifc.wr_be_i;
`else
    return 4'hF;
`endif
  endfunction

  task automatic idle();
    ifc.wr_valid_i = 1'b0;
    ifc.wr_dir_i   = '0;
    ifc.wr_dat_i   = '0;
    ifc.rd_en_i    = 1'b0;
    ifc.rd_dir_i   = '0;
`ifdef RAM_BYTE_MASK_EN
    ifc.wr_be_i    = 4'hF;
`endif
  endtask

  // One clock: push the expected read, advance the model at the edge, then
  // check all outputs 1 time unit after the edge.
  task automatic tick();
    logic        pre;
    logic [31:0] rexp;
    pre = ifc.rd_en_i && ready_m && !rst;
    if (pre) exp_q.push_back(mem_m[ifc.rd_dir_i]);
    @(posedge clk);
    if (rst) begin
      clr_cnt = 0;
    end else if (clr_cnt < NENT) begin
      mem_m[clr_cnt] = INIT;
      clr_cnt++;
    end else if (ifc.wr_valid_i) begin
      mem_m[ifc.wr_dir_i] = merge(mem_m[ifc.wr_dir_i], ifc.wr_dat_i, cur_be());
    end
    ready_m = !rst && (clr_cnt >= NENT);
    #1;
    check("rd_valid", {31'b0, ifc.rd_valid_o}, {31'b0, pre});
    if (pre) begin
      rexp = exp_q.pop_front();
      check("rd_dat", ifc.rd_dat_o, rexp);
      last_rd = rexp;
    end else begin
      check("rd_hold", ifc.rd_dat_o, last_rd);
    end
    check("wr_ready", {31'b0, ifc.wr_ready_o}, {31'b0, ready_m});
    check("init_done", {31'b0, ifc.init_done_o}, {31'b0, ready_m});
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    ready_m = 1'b0;
    clr_cnt = 0;
    last_rd = '0;
    exp_q.delete();
    #1;
    check("rst_rd_valid", {31'b0, ifc.rd_valid_o}, 32'd0);
    check("rst_wr_ready", {31'b0, ifc.wr_ready_o}, 32'd0);
    check("rst_init_done", {31'b0, ifc.init_done_o}, 32'd0);
    check("rst_rd_dat", ifc.rd_dat_o, 32'd0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (ifc.init_done_o) break;
    end
    check("init_latency", 32'(cnt), 32'd16);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    ifc.wr_valid_i = 1'b1;
    ifc.wr_dir_i   = a;
    ifc.wr_dat_i   = d;
  endtask

  task automatic rd(input logic [3:0] a);
    ifc.rd_en_i  = 1'b1;
    ifc.rd_dir_i = a;
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) mem_m[i] = 32'hbad0_bad0;
    idle();
    last_rd = '0;

    // Reset release with requests pending during the clear window.
    do_reset(3);
    wr(4'h5, 32'hdead_beef);
    rd(4'h5);
    wait_init();
    idle();
    for (int i = 0; i < NENT; i++) begin
      rd(4'(i));
      tick();
    end
    idle();
    tick();

    // Back-to-back writes, then reads.
    wr(4'h1, 32'h777a_bcfe); tick();
    wr(4'h2, 32'h4815_1623); tick();
    wr(4'hF, 32'hffff_ffff); tick();
    idle();
    rd(4'h1); tick();
    rd(4'h2); tick();
    rd(4'hF); tick();
    idle(); tick();

    // Same-address collision: read-first.
    wr(4'h3, 32'hfedc_ba98); tick();
    wr(4'h3, 32'haabb_ccdd); rd(4'h3); tick();
    idle();
    rd(4'h3); tick();
    idle(); tick();

    // Independent write/read to different addresses.
    wr(4'h4, 32'h1111_2222); rd(4'h1); tick();
    idle(); rd(4'h4); tick();
    idle(); tick();

`ifdef RAM_BYTE_MASK_EN
    wr(4'h9, 32'hffaa_9911); tick();
    wr(4'h9, 32'h1234_5678); ifc.wr_be_i = 4'b0101; tick();
    wr(4'h9, 32'h0000_0000); ifc.wr_be_i = 4'b0000; tick();
    idle();
    rd(4'h9); tick();
    idle(); tick();
    check("mask_model", mem_m[9], 32'hff34_9978);
`endif

    // Short randomized mix.
    for (int i = 0; i < 40; i++) begin
      ifc.wr_valid_i = 1'($urandom_range(0, 1));
      ifc.wr_dir_i   = 4'($urandom_range(0, 15));
      ifc.wr_dat_i   = $urandom;
      ifc.rd_en_i    = 1'($urandom_range(0, 1));
      ifc.rd_dir_i   = 4'($urandom_range(0, 15));
`ifdef RAM_BYTE_MASK_EN
      ifc.wr_be_i    = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    idle(); tick();

    // Reset in the same cycle as a read of the freshly written entry.
    wr(4'h6, 32'h0246_8ace); tick();
    idle();
    rd(4'h6);
    do_reset(2);
    idle();
    wait_init();
    rd(4'h6); tick();
    idle(); tick();

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_wr.md
Name: ram_wr

Overview:
- 16-entry x 32-bit writable data memory; the write-side counterpart to the constant lookup memory in the ALU datapath.
- After reset, an internal sequencer clears every entry to INIT_VAL, one entry per clock.
- It then accepts single-word writes over a valid/ready handshake.
- It serves registered reads with 1-cycle latency to the ALU operand path.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 4, address width; depth = 2**ADDR_W (16).
- INIT_VAL, 32'h00000000, value written to every entry by the post-reset clear sequence.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  block can accept a write this cycle.
- wr_dir_i  in  ADDR_W  write address.
- wr_dat_i  in  DATA_W  write data.
- rd_en_i  in  1  read request.
- rd_dir_i  in  ADDR_W  read address.
- rd_dat_o  out  DATA_W  registered read data.
- rd_valid_o  out  1  rd_dat_o holds the result of the read issued the previous cycle.
- init_done_o  out  1  clear sequence complete; memory is usable.

Behaviour:
- Reset values while rst_i=1:
  - FSM = CLEAR, clear pointer = 0.
  - wr_ready_o=0, rd_valid_o=0, rd_dat_o=0, init_done_o=0.
  - Array contents are not reset directly; the CLEAR state overwrites them.
- FSM state CLEAR:
  - Each cycle, mem[ptr] <= INIT_VAL and ptr increments.
  - When ptr = depth-1 is written, go to READY.
  - Duration is exactly 16 cycles after reset release.
  - wr_ready_o=0; wr_valid_i and rd_en_i are ignored; rd_valid_o stays 0.
- FSM state READY:
  - init_done_o=1 and wr_ready_o=1, both registered.
  - Both assert on the first cycle after the last clear write.
  - The FSM stays in READY until reset.
- Write commit:
  - A write commits when wr_valid_i & wr_ready_o are high at a rising edge: mem[wr_dir_i] <= wr_dat_i.
  - One write per cycle; back-to-back writes are allowed with no bubble.
- Read:
  - When rd_en_i=1 in READY, rd_dat_o <= mem[rd_dir_i] and rd_valid_o <= 1 on the next edge.
  - If rd_en_i=0, rd_valid_o <= 0 and rd_dat_o holds its last value.
- Read and write to the same address in the same cycle: read-first. rd_dat_o returns the old contents; the new value is visible on the next read.
- Simultaneous writes/reads to different addresses are fully independent.
- Addresses are full-range (4 bits cover all 16 entries), so there is no out-of-range case.
- rst_i asserted mid-operation:
  - Immediately drops wr_ready_o, rd_valid_o and init_done_o.
  - Any in-flight read is discarded.
  - On release, the full 16-cycle clear sequence restarts from entry 0.
- No backpressure on reads.
- wr_ready_o depends only on FSM state, never on wr_valid_i.

Optional Feature:
- Macro: RAM_BYTE_MASK_EN.
- Defined:
  - Adds input wr_be_i [DATA_W/8-1:0].
  - On a write commit, only the bytes whose enable bit is 1 are updated; the other bytes keep their old value.
  - wr_be_i = 0 is a legal no-op that still completes the handshake.
  - The CLEAR state ignores the mask and writes all bytes.
- Undefined:
  - No wr_be_i port; every write updates the full word.

Decomposition:
- Shared package alu_pkg:
  - Default DATA_W/ADDR_W constants.
  - FSM state encoding: CLEAR=1'b0, READY=1'b1.
  - INIT_VAL default.
- One natural sub-module: ram_wr_clear_seq.
  - Contains the clear pointer and the CLEAR→READY FSM.
  - Outputs the clear write enable, clear address and init_done.
- The array and read register stay in ram_wr.

Test Plan:
- Reset release:
  - Stimulus: hold rst_i 3 cycles, release; then read addresses 0x0..0xF.
  - Required: init_done_o and wr_ready_o rise exactly 16 cycles after release; every read returns 32'h00000000.
- Back-to-back writes:
  - Stimulus: write 0x777abcfe@0x1, 0x48151623@0x2, 0xffffffff@0xF on consecutive cycles; then read 0x1, 0x2, 0xF.
  - Required: 0x777abcfe, 0x48151623, 0xffffffff, each with rd_valid_o=1 exactly one cycle after its rd_en_i.
- Same-address collision:
  - Setup: mem[0x3]=0xfedcba98.
  - Stimulus: write 0xaabbccdd@0x3 and read 0x3 in the same cycle.
  - Required: rd_dat_o=0xfedcba98; the next read of 0x3 returns 0xaabbccdd.
- Requests during CLEAR:
  - Stimulus: drive wr_valid_i=1 and rd_en_i=1 during the clear window.
  - Required: wr_ready_o=0, rd_valid_o=0; after init, a read of the targeted address returns INIT_VAL.
- Reset mid-operation:
  - Stimulus: write 0x02468ace@0x6, then assert rst_i the same cycle as a read of 0x6.
  - Required: rd_valid_o=0; after re-init, a read of 0x6 returns 0x00000000.
- RAM_BYTE_MASK_EN (run only with the macro defined):
  - Setup: mem[0x9]=0xffaa9911.
  - Stimulus: write 0x12345678 with wr_be_i=4'b0101.
  - Required: a read of 0x9 returns 0xff349978.
